// File: rtl/rnn_fixed_pkg.sv
// Shared Q16.16 constants, encodings and the tanh table generator
// for the RNN denoise datapath.
package rnn_fixed_pkg;

   localparam int DATA_W      = 32;
   localparam int FRAC_W      = 16;
   localparam int ACC_W       = 48;
   localparam int SCALE_SHIFT = 8;
   localparam int ADDR_W      = 16;
   localparam int LUT_N       = 1024;
   localparam int LUT_W       = 17;

   localparam logic signed [DATA_W-1:0] ONE       = 32'h0001_0000;
   localparam logic signed [DATA_W-1:0] HALF      = 32'h0000_8000;
   localparam logic signed [DATA_W-1:0] MINUS_ONE = 32'hFFFF_0000;

   typedef enum logic [1:0] {
      ACT_LINEAR  = 2'd0,
      ACT_RELU    = 2'd1,
      ACT_TANH    = 2'd2,
      ACT_SIGMOID = 2'd3
   } act_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_MAC,
      S_DRAIN,
      S_ACT,
      S_WRITE,
      S_DONE
   } state_e;

   localparam logic [127:0] Q32      = 128'd1 << 32;
   // e^(1/128) in Q32: one table step of exp(2x) at x = i/256
   localparam logic [127:0] EXP_STEP = 128'd4328653142;

   // Entry i = round(tanh(i/256) * 2^16), via tanh = (E-1)/(E+1), E = exp(2x)
   function automatic logic [LUT_N*LUT_W-1:0] tanh_table();
      logic [LUT_N*LUT_W-1:0] tbl;
      logic [127:0] e;
      logic [127:0] num;
      logic [127:0] den;
      tbl = '0;
      e   = Q32;
      for (int h = 0; h < 32; h++) begin
         for (int l = 0; l < 32; l++) begin
            num = ((e - Q32) << 17) + e + Q32;
            den = (e + Q32) << 1;
            tbl[(h*32+l)*LUT_W +: LUT_W] = LUT_W'(num / den);
            e = (e * EXP_STEP + (Q32 >> 1)) >> 32;
         end
      end
      return tbl;
   endfunction

endpackage

// File: rtl/tanh_lut_interp.sv
// Q16.16 tanh: |x| -> registered table pair -> linear interpolation,
// saturation at |x| >= 4.0 and sign restore. Result valid a cycle after x.
module tanh_lut_interp
   import rnn_fixed_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] t
);

   localparam logic [LUT_N*LUT_W-1:0] LUT = tanh_table();

   logic              neg;
   logic              sat;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] mix;
   logic [9:0]        idx;
   logic [9:0]        idx_hi;
   logic [7:0]        f;
   logic [LUT_W-1:0]  lo_q;
   logic [LUT_W-1:0]  hi_q;

   assign neg    = x[DATA_W-1];
   assign a      = neg ? -x : x;
   assign sat    = |a[DATA_W-1:18];
   assign idx    = a[17:8];
   assign f      = a[7:0];
   assign idx_hi = (&idx) ? idx : idx + 10'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         lo_q <= LUT[int'(idx)*LUT_W +: LUT_W];
         hi_q <= LUT[int'(idx_hi)*LUT_W +: LUT_W];
      end
   end

   assign mix = (32'(lo_q) * (32'd256 - 32'(f))
               + 32'(hi_q) * 32'(f)) >> 8;

   assign t = sat ? (neg ? MINUS_ONE : ONE)
                  : (neg ? -mix : mix);

endmodule

// File: rtl/dense_layer_engine.sv
// Fixed-point fully-connected layer: out[j] = act((bias[j] + sum w*in) >>> 8),
// one neuron every M+4 cycles against 1-cycle-latency external RAMs.
module dense_layer_engine
   import rnn_fixed_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        nb_inputs,
   input  logic [7:0]        nb_neurons,
   input  logic [1:0]        act_mode,
   input  logic [ADDR_W-1:0] w_offset,
   input  logic [ADDR_W-1:0] b_offset,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic [7:0]        in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_we,
   output logic [7:0]        out_addr,
   output logic [DATA_W-1:0] out_data
);

   state_e state;
   state_e nxt;

   logic [7:0]        m_r;
   logic [7:0]        n_r;
   logic [7:0]        j_r;
   logic [7:0]        k_r;
   act_e              mode_r;
   logic [ADDR_W-1:0] woff_r;
   logic [ADDR_W-1:0] boff_r;
   logic [ADDR_W-1:0] wrow_r;

   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    sh;
   logic signed [ACC_W-1:0]    prod;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [2*DATA_W-1:0] prod_full;
   logic signed [DATA_W-1:0]   x;
   logic signed [DATA_W-1:0]   x_half;
   logic signed [DATA_W-1:0]   tin;
   logic signed [DATA_W-1:0]   t_val;
   logic signed [DATA_W-1:0]   t_half;
   logic signed [DATA_W-1:0]   res;
   logic                       load_bias;
   logic                       unused_bits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (start) nxt = (nb_neurons == 8'd0) ? S_DONE : S_BIAS;
         S_BIAS:  nxt = (m_r == 8'd0) ? S_DRAIN : S_MAC;
         S_MAC:   if (k_r == m_r - 8'd1) nxt = S_DRAIN;
         S_DRAIN: nxt = S_ACT;
         S_ACT:   nxt = S_WRITE;
         S_WRITE: nxt = (j_r == n_r - 8'd1) ? S_DONE : S_BIAS;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   assign prod_full = $signed(w_data) * $signed(in_data);
   assign prod      = prod_full[2*DATA_W-1:FRAC_W];
   assign bias_ext  = {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data};
   assign unused_bits = ^prod_full[FRAC_W-1:0];

   // Bias arrives one cycle after BIAS: first MAC cycle, or DRAIN when M=0
   assign load_bias = (state == S_MAC && k_r == 8'd0)
                   || (state == S_DRAIN && m_r == 8'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_r    <= '0;
         n_r    <= '0;
         j_r    <= '0;
         k_r    <= '0;
         mode_r <= ACT_LINEAR;
         woff_r <= '0;
         boff_r <= '0;
         wrow_r <= '0;
         acc    <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            m_r    <= nb_inputs;
            n_r    <= nb_neurons;
            mode_r <= act_e'(act_mode);
            woff_r <= w_offset;
            boff_r <= b_offset;
            j_r    <= '0;
         end
         if (state == S_BIAS) begin
            k_r    <= '0;
            wrow_r <= woff_r;
         end
         if (state == S_MAC) begin
            k_r    <= k_r + 8'd1;
            wrow_r <= wrow_r + {{(ADDR_W-8){1'b0}}, n_r};
         end
         if (state == S_WRITE) j_r <= j_r + 8'd1;
         if (load_bias)
            acc <= bias_ext;
         else if (state == S_MAC || state == S_DRAIN)
            acc <= acc + prod;
      end
   end

   assign sh = acc >>> SCALE_SHIFT;

   always_comb begin
      x = sh[DATA_W-1:0];
      if (!(&sh[ACC_W-1:DATA_W-1]) && (|sh[ACC_W-1:DATA_W-1]))
         x = sh[ACC_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
   end

   assign x_half = x >>> 1;
   assign tin    = (mode_r == ACT_SIGMOID) ? x_half : x;

   tanh_lut_interp u_tanh (
      .clk (clk),
      .rst (rst),
      .x   (tin),
      .t   (t_val)
   );

   assign t_half = t_val >>> 1;

   always_comb begin
      res = x;
      unique case (mode_r)
         ACT_LINEAR:  res = x;
         ACT_RELU:    res = x[DATA_W-1] ? '0 : x;
         ACT_TANH:    res = t_val;
         ACT_SIGMOID: res = HALF + t_half;
      endcase
   end

   assign w_addr   = wrow_r + {{(ADDR_W-8){1'b0}}, j_r};
   assign b_addr   = boff_r + {{(ADDR_W-8){1'b0}}, j_r};
   assign in_addr  = k_r;
   assign out_addr = j_r;
   assign out_data = res;
   assign out_we   = (state == S_WRITE);
   assign done     = (state == S_DONE);
   assign busy     = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine with synchronous RAM models.
module tb_dense_layer_engine;

   localparam int LIMIT = 3000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  nb_inputs = '0;
   logic [7:0]  nb_neurons = '0;
   logic [1:0]  act_mode = '0;
   logic [15:0] w_offset = '0;
   logic [15:0] b_offset = '0;
   logic        busy;
   logic        done;
   logic [15:0] w_addr;
   logic [31:0] w_data = '0;
   logic [15:0] b_addr;
   logic [31:0] b_data = '0;
   logic [7:0]  in_addr;
   logic [31:0] in_data = '0;
   logic        out_we;
   logic [7:0]  out_addr;
   logic [31:0] out_data;

   logic [31:0] wmem [65536];
   logic [31:0] bmem [65536];
   logic [31:0] imem [256];
   logic [31:0] out_mem [256];
   logic [15:0] wa_log [64];
   logic [15:0] ba_log [64];

   int n_chk = 0;
   int n_pass = 0;
   int nwr = 0;
   int lat;
   int diff;
   int errs;

   dense_layer_engine dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .nb_inputs  (nb_inputs),
      .nb_neurons (nb_neurons),
      .act_mode   (act_mode),
      .w_offset   (w_offset),
      .b_offset   (b_offset),
      .busy       (busy),
      .done       (done),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .b_addr     (b_addr),
      .b_data     (b_data),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .out_we     (out_we),
      .out_addr   (out_addr),
      .out_data   (out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      w_data  <= wmem[w_addr];
      b_data  <= bmem[b_addr];
      in_data <= imem[in_addr];
   end

   always @(negedge clk) begin
      if (out_we) begin
         out_mem[out_addr] = out_data;
         nwr = nwr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic run_layer(input int m, input int n, input logic [1:0] mode,
                            input logic [15:0] wo, input logic [15:0] bo,
                            input bit poke, output int l);
      for (int i = 0; i < 256; i++) out_mem[i] = 32'hDEAD_BEEF;
      for (int i = 0; i < 64; i++) begin
         wa_log[i] = '0;
         ba_log[i] = '0;
      end
      @(negedge clk);
      nwr        = 0;
      nb_inputs  = 8'(m);
      nb_neurons = 8'(n);
      act_mode   = mode;
      w_offset   = wo;
      b_offset   = bo;
      start      = 1'b1;
      l = 0;
      while (l < LIMIT) begin
         @(posedge clk);
         l++;
         @(negedge clk);
         start = 1'b0;
         if (poke && l == 2) begin
            start      = 1'b1;
            nb_neurons = 8'd5;
            act_mode   = 2'd1;
         end
         if (l < 64) begin
            wa_log[l] = w_addr;
            ba_log[l] = b_addr;
         end
         if (done) break;
      end
      if (l >= LIMIT) check("done_timeout", {31'b0, done}, 1);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         wmem[i] = '0;
         bmem[i] = '0;
      end
      for (int i = 0; i < 256; i++) imem[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_we", {31'b0, out_we}, 0);
      check("rst_waddr", {16'b0, w_addr}, 0);
      check("rst_baddr", {16'b0, b_addr}, 0);
      check("rst_inaddr", {24'b0, in_addr}, 0);
      rst = 1'b0;

      // linear M=1 N=1
      wmem[0] = 32'h0100_0000;
      imem[0] = 32'h0001_0000;
      run_layer(1, 1, 2'd0, 16'd0, 16'd0, 1'b0, lat);
      check("lin_lat", lat, 6);
      check("lin_writes", nwr, 1);
      check("lin_out0", out_mem[0], 32'h0001_0000);

      // restart and config change while busy are ignored
      run_layer(1, 1, 2'd0, 16'd0, 16'd0, 1'b1, lat);
      check("poke_lat", lat, 6);
      check("poke_writes", nwr, 1);
      check("poke_out0", out_mem[0], 32'h0001_0000);

      // relu M=2 N=2
      for (int i = 0; i < 4; i++) wmem[i] = 32'h0100_0000;
      imem[0] = 32'hFFFF_0000;
      imem[1] = 32'h0000_0000;
      run_layer(2, 2, 2'd1, 16'd0, 16'd0, 1'b0, lat);
      check("relu_lat", lat, 13);
      check("relu_neg0", out_mem[0], 0);
      check("relu_neg1", out_mem[1], 0);
      imem[0] = 32'h0002_0000;
      imem[1] = 32'h0001_0000;
      run_layer(2, 2, 2'd1, 16'd0, 16'd0, 1'b0, lat);
      check("relu_pos0", out_mem[0], 32'h0003_0000);
      check("relu_pos1", out_mem[1], 32'h0003_0000);

      // tanh via bias only: x = bias >>> 8
      bmem[0] = 32'h0000_0000;
      bmem[1] = 32'h0500_0000;
      bmem[2] = 32'hFB00_0000;
      bmem[3] = 32'h0080_0000;
      run_layer(0, 4, 2'd2, 16'd0, 16'd0, 1'b0, lat);
      check("tanh_lat", lat, 17);
      check("tanh_zero", out_mem[0], 0);
      check("tanh_pos5", out_mem[1], 32'h0001_0000);
      check("tanh_neg5", out_mem[2], 32'hFFFF_0000);
      diff = int'(out_mem[3]) - 30285;
      check("tanh_half", {31'b0, (diff >= -1 && diff <= 1)}, 1);

      // sigmoid
      bmem[0] = 32'h0000_0000;
      bmem[1] = 32'h0A00_0000;
      bmem[2] = 32'hF600_0000;
      run_layer(0, 3, 2'd3, 16'd0, 16'd0, 1'b0, lat);
      check("sig_zero", out_mem[0], 32'h0000_8000);
      check("sig_pos10", out_mem[1], 32'h0001_0000);
      check("sig_neg10", out_mem[2], 0);

      // M=0 edge
      bmem[0] = 32'h0000_0100;
      bmem[1] = 32'h0000_0200;
      bmem[2] = 32'h0000_0300;
      run_layer(0, 3, 2'd0, 16'd0, 16'd0, 1'b0, lat);
      check("m0_lat", lat, 13);
      check("m0_out0", out_mem[0], 1);
      check("m0_out1", out_mem[1], 2);
      check("m0_out2", out_mem[2], 3);

      // N=0 edge
      run_layer(3, 0, 2'd0, 16'd0, 16'd0, 1'b0, lat);
      check("n0_lat", lat, 1);
      check("n0_writes", nwr, 0);

      // weight/bias offsets
      for (int i = 0; i < 256; i++) wmem[i] = 32'h5500_0000;
      for (int i = 0; i < 64; i++) bmem[i] = 32'h7F00_0000;
      wmem[72] = 32'h0100_0000;
      wmem[73] = 32'h0200_0000;
      wmem[74] = 32'h0300_0000;
      wmem[75] = 32'h0400_0000;
      bmem[24] = 32'h0100_0000;
      bmem[25] = 32'h0200_0000;
      imem[0]  = 32'h0001_0000;
      imem[1]  = 32'h0002_0000;
      run_layer(2, 2, 2'd0, 16'd72, 16'd24, 1'b0, lat);
      check("off_b0", {16'b0, ba_log[1]}, 24);
      check("off_b1", {16'b0, ba_log[7]}, 25);
      check("off_w00", {16'b0, wa_log[2]}, 72);
      check("off_w10", {16'b0, wa_log[3]}, 74);
      check("off_w01", {16'b0, wa_log[8]}, 73);
      check("off_w11", {16'b0, wa_log[9]}, 75);
      check("off_out0", out_mem[0], 32'h0008_0000);
      check("off_out1", out_mem[1], 32'h000C_0000);

      // reset mid-MAC of neuron 5, M=42 N=24
      for (int i = 0; i < 42*24; i++) wmem[i] = 32'h0100_0000;
      for (int k = 0; k < 42; k++) imem[k] = 32'h0001_0000;
      for (int j = 0; j < 24; j++) bmem[j] = 32'(j) << 24;
      @(negedge clk);
      nwr        = 0;
      nb_inputs  = 8'd42;
      nb_neurons = 8'd24;
      act_mode   = 2'd0;
      w_offset   = '0;
      b_offset   = '0;
      start      = 1'b1;
      for (int c = 0; c < 250; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      check("rst_pre_writes", nwr, 5);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", {31'b0, busy}, 0);
      check("rst_mid_we", {31'b0, out_we}, 0);
      @(negedge clk);
      rst = 1'b0;
      run_layer(42, 24, 2'd0, 16'd0, 16'd0, 1'b0, lat);
      check("big_lat", lat, 24*46+1);
      check("big_writes", nwr, 24);
      check("big_out0", out_mem[0], 32'h002A_0000);
      check("big_out23", out_mem[23], 32'h0041_0000);
      errs = 0;
      for (int j = 0; j < 24; j++)
         if (out_mem[j] !== (32'(42 + j) << 16)) errs++;
      check("big_all", errs, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
